controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/riscpkg.sv | 34 +++
 rtl/op_decode.sv | 23 ++
 rtl/controller.sv | 129 ++++++++++++
 tb/tb_controller.sv | 108 ++++++++++
 4 files changed

// File: rtl/riscpkg.sv
// riscpkg: shared state, opcode and mux-select encodings for the controller and datapath.
package riscpkg;
    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEMRD, S_MEMWR, S_WB, S_MULTI, S_PCINC
    } state_t;

    typedef enum logic [3:0] {
        C_ADD, C_ADI, C_NDU, C_LHI, C_LW, C_SW, C_LM, C_SM, C_JMP, C_BEQ, C_UND
    } iclass_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    localparam logic [1:0] B_ZERO = 2'd0, B_ONE = 2'd1, B_REG = 2'd2, B_IMM6 = 2'd3;
    localparam logic [2:0] A_ZERO = 3'd0, A_ONE = 3'd1, A_SHIFT7 = 3'd2, A_IMM6 = 3'd3,
                           A_IMM9 = 3'd4, A_REG = 3'd5, A_TMPA = 3'd6;
    localparam logic [1:0] WEN_OFF = 2'd0, WEN_ON = 2'd1, WEN_CZ = 2'd2, WEN_IRBIT = 2'd3;
    localparam logic [2:0] WADD_IR119 = 3'd0, WADD_IR53 = 3'd1, WADD_CNT = 3'd2,
                           WADD_R7 = 3'd3, WADD_IR86 = 3'd4;
    localparam logic [1:0] RD2_IR86 = 2'd0, RD2_CNT = 2'd1, RD2_R7 = 2'd2;
    localparam logic       DIN_MEM = 1'b0, DIN_T1 = 1'b1;
    localparam logic [1:0] MW_OFF = 2'd0, MW_ON = 2'd1, MW_IRBIT = 2'd2;
    localparam logic       MDI_A = 1'b0, MDI_B = 1'b1;
    localparam logic       ALU_ADD = 1'b0, ALU_NAND = 1'b1;
endpackage

// File: rtl/op_decode.sv
// op_decode: maps an opcode to the instruction class that steers the controller.
import riscpkg::*;

module op_decode (
    input  logic [3:0] opcode,
    output iclass_t    iclass
);
    always_comb begin
        case (opcode)
            OP_ADD:         iclass = C_ADD;
            OP_ADI:         iclass = C_ADI;
            OP_NDU:         iclass = C_NDU;
            OP_LHI:         iclass = C_LHI;
            OP_LW:          iclass = C_LW;
            OP_SW:          iclass = C_SW;
            OP_LM:          iclass = C_LM;
            OP_SM:          iclass = C_SM;
            OP_JAL, OP_JLR: iclass = C_JMP;
            OP_BEQ:         iclass = C_BEQ;
            default:        iclass = C_UND;
        endcase
    end
endmodule

// File: rtl/controller.sv
// controller: multicycle Moore FSM producing datapath mux selects and enables.
import riscpkg::*;

module controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        compare,
    output logic [1:0]  Mux1_alu_B,
    output logic [2:0]  Mux2_alu_A,
    output logic [1:0]  Mux3_RF_wen,
    output logic [2:0]  Mux4_RF_wadd,
    output logic [1:0]  Mux5_RF_read2,
    output logic        Mux6_RF_dataIn,
    output logic [1:0]  Mux8_memwrite,
    output logic        Mux9_memDataIn,
    output logic        CZ_en,
    output logic        ALU_op,
    output logic        wIR,
    output logic        wAtmp,
    output logic        resetT1,
    output logic [2:0]  counter
);
    state_t     state_q, state_d;
    iclass_t    cls_q, cls_d, dec_cls;
    logic [2:0] counter_q, counter_d;
    logic       branch_taken_q, branch_taken_d;
    logic       unused_ir;

    assign unused_ir = ^ir[11:0];
    assign counter   = counter_q;

    op_decode u_op_decode (.opcode(ir[15:12]), .iclass(dec_cls));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_RST;
            cls_q          <= C_UND;
            counter_q      <= '0;
            branch_taken_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cls_q          <= cls_d;
            counter_q      <= counter_d;
            branch_taken_q <= branch_taken_d;
        end
    end

    // Class is captured in DECODE so later states depend only on registered values.
    always_comb begin
        state_d        = state_q;
        cls_d          = cls_q;
        counter_d      = '0;
        branch_taken_d = branch_taken_q;
        Mux1_alu_B     = B_ZERO;
        Mux2_alu_A     = A_ZERO;
        Mux3_RF_wen    = WEN_OFF;
        Mux4_RF_wadd   = WADD_IR119;
        Mux5_RF_read2  = RD2_IR86;
        Mux6_RF_dataIn = DIN_MEM;
        Mux8_memwrite  = MW_OFF;
        Mux9_memDataIn = MDI_A;
        CZ_en          = 1'b0;
        ALU_op         = ALU_ADD;
        wIR            = 1'b0;
        wAtmp          = 1'b0;
        resetT1        = 1'b0;
        case (state_q)
            S_RST: begin
                resetT1 = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                wIR            = 1'b1;
                branch_taken_d = 1'b0;
                state_d        = S_DECODE;
            end
            S_DECODE: begin
                wAtmp   = 1'b1;
                cls_d   = dec_cls;
                state_d = (dec_cls inside {C_ADD, C_ADI, C_NDU, C_LHI, C_LW, C_SW, C_BEQ}) ? S_EXEC :
                          (dec_cls inside {C_LM, C_SM}) ? S_MULTI :
                          (dec_cls == C_JMP) ? S_WB : S_PCINC;
            end
            S_EXEC: begin
                branch_taken_d = compare;
                Mux2_alu_A     = (cls_q == C_LHI) ? A_SHIFT7 : (cls_q inside {C_LW, C_SW}) ? A_IMM6 : A_REG;
                Mux1_alu_B     = (cls_q == C_LHI) ? B_ZERO : (cls_q == C_ADI) ? B_IMM6 : B_REG;
                ALU_op         = (cls_q == C_NDU) ? ALU_NAND : ALU_ADD;
                CZ_en          = cls_q inside {C_ADD, C_ADI, C_NDU};
                state_d        = (cls_q == C_LW) ? S_MEMRD : (cls_q == C_SW) ? S_MEMWR :
                                 (cls_q == C_BEQ) ? S_PCINC : S_WB;
            end
            S_MEMRD: begin
                Mux3_RF_wen = WEN_ON;
                state_d     = S_PCINC;
            end
            S_MEMWR: begin
                Mux8_memwrite = MW_ON;
                state_d       = S_PCINC;
            end
            S_WB: begin
                Mux6_RF_dataIn = DIN_T1;
                Mux3_RF_wen    = (cls_q inside {C_ADD, C_NDU}) ? WEN_CZ : WEN_ON;
                Mux4_RF_wadd   = (cls_q inside {C_ADD, C_NDU}) ? WADD_IR53 : (cls_q == C_ADI) ? WADD_IR86 :
                                 (cls_q == C_JMP) ? WADD_R7 : WADD_IR119;
                state_d        = S_PCINC;
            end
            S_MULTI: begin
                counter_d      = counter_q + 3'd1;
                Mux3_RF_wen    = (cls_q == C_LM) ? WEN_IRBIT : WEN_OFF;
                Mux4_RF_wadd   = (cls_q == C_LM) ? WADD_CNT : WADD_IR119;
                Mux8_memwrite  = (cls_q == C_SM) ? MW_IRBIT : MW_OFF;
                Mux5_RF_read2  = (cls_q == C_SM) ? RD2_CNT : RD2_IR86;
                Mux9_memDataIn = (cls_q == C_SM) ? MDI_B : MDI_A;
                state_d        = (counter_q == 3'd7) ? S_PCINC : S_MULTI;
            end
            S_PCINC: begin
                Mux2_alu_A    = A_REG;
                Mux5_RF_read2 = RD2_R7;
                Mux1_alu_B    = (cls_q == C_BEQ && branch_taken_q) ? B_IMM6 : B_ONE;
                Mux3_RF_wen   = WEN_ON;
                Mux4_RF_wadd  = WADD_R7;
                state_d       = S_FETCH;
            end
            default: state_d = S_RST;
        endcase
    end
endmodule

// File: tb/tb_controller.sv
// tb_controller: random and directed instruction streams checked cycle by cycle against a per-opcode output table.
module tb_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ir = '0;
    logic        compare = 1'b0;
    logic [1:0]  Mux1_alu_B, Mux3_RF_wen, Mux5_RF_read2, Mux8_memwrite;
    logic [2:0]  Mux2_alu_A, Mux4_RF_wadd, counter;
    logic        Mux6_RF_dataIn, Mux9_memDataIn, CZ_en, ALU_op, wIR, wAtmp, resetT1;
    logic [23:0] obs;
    logic [23:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    controller dut (
        .clk(clk), .reset(reset), .ir(ir), .compare(compare),
        .Mux1_alu_B(Mux1_alu_B), .Mux2_alu_A(Mux2_alu_A), .Mux3_RF_wen(Mux3_RF_wen),
        .Mux4_RF_wadd(Mux4_RF_wadd), .Mux5_RF_read2(Mux5_RF_read2), .Mux6_RF_dataIn(Mux6_RF_dataIn),
        .Mux8_memwrite(Mux8_memwrite), .Mux9_memDataIn(Mux9_memDataIn), .CZ_en(CZ_en),
        .ALU_op(ALU_op), .wIR(wIR), .wAtmp(wAtmp), .resetT1(resetT1), .counter(counter)
    );

    assign obs = {Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2, Mux6_RF_dataIn,
                  Mux8_memwrite, Mux9_memDataIn, CZ_en, ALU_op, wIR, wAtmp, resetT1, counter};

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Field order: B, A, wen, wadd, read2, dataIn, memwrite, memDataIn, CZ, op, wIR, wAtmp, resetT1, counter
    function automatic logic [23:0] v(input int b, a, wen, wadd, rd2, din, mw, mdi, cz, op, wir, wat, rt, cnt);
        return {b[1:0], a[2:0], wen[1:0], wadd[2:0], rd2[1:0], din[0], mw[1:0], mdi[0],
                cz[0], op[0], wir[0], wat[0], rt[0], cnt[2:0]};
    endfunction

    function automatic void build(input logic [3:0] opc, input bit c);
        exp_q.delete();
        exp_q.push_back(v(0,0,0,0,0,0,0,0,0,0,1,0,0,0));
        exp_q.push_back(v(0,0,0,0,0,0,0,0,0,0,0,1,0,0));
        case (opc)
            4'd0: begin exp_q.push_back(v(2,5,0,0,0,0,0,0,1,0,0,0,0,0)); exp_q.push_back(v(0,0,2,1,0,1,0,0,0,0,0,0,0,0)); end
            4'd1: begin exp_q.push_back(v(3,5,0,0,0,0,0,0,1,0,0,0,0,0)); exp_q.push_back(v(0,0,1,4,0,1,0,0,0,0,0,0,0,0)); end
            4'd2: begin exp_q.push_back(v(2,5,0,0,0,0,0,0,1,1,0,0,0,0)); exp_q.push_back(v(0,0,2,1,0,1,0,0,0,0,0,0,0,0)); end
            4'd3: begin exp_q.push_back(v(0,2,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(v(0,0,1,0,0,1,0,0,0,0,0,0,0,0)); end
            4'd4: begin exp_q.push_back(v(2,3,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(v(0,0,1,0,0,0,0,0,0,0,0,0,0,0)); end
            4'd5: begin exp_q.push_back(v(2,3,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(v(0,0,0,0,0,0,1,0,0,0,0,0,0,0)); end
            4'd6: for (int k = 0; k < 8; k++) exp_q.push_back(v(0,0,3,2,0,0,0,0,0,0,0,0,0,k));
            4'd7: for (int k = 0; k < 8; k++) exp_q.push_back(v(0,0,0,0,1,0,2,1,0,0,0,0,0,k));
            4'd8, 4'd9: exp_q.push_back(v(0,0,1,3,0,1,0,0,0,0,0,0,0,0));
            4'd12: exp_q.push_back(v(2,5,0,0,0,0,0,0,0,0,0,0,0,0));
            default: ;
        endcase
        exp_q.push_back(v((opc == 4'd12 && c) ? 3 : 1, 5, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    // Compare carries c only during the third cycle (EXEC for ALU/memory/branch ops) and ~c otherwise.
    task automatic run(input logic [15:0] instr, input bit c, input int abort_at);
        build(instr[15:12], c);
        foreach (exp_q[i]) begin
            @(negedge clk);
            check($sformatf("op%h_c%0d_cyc%0d", instr[15:12], c, i), obs, exp_q[i]);
            if (i == 0) ir = instr;
            compare = (i == 2) ? c : ~c;
            if (i == abort_at) begin
                reset = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [23:0] rst_v;
        rst_v = v(0,0,0,0,0,0,0,0,0,0,0,0,1,0);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", obs, rst_v);
        end
        reset = 1'b0;
        run(16'h0000, 1'b0, -1);
        run(16'hC000, 1'b1, -1);
        run(16'hC000, 1'b0, -1);
        run(16'h6000, 1'b0, -1);
        run(16'h7ABC, 1'b1, -1);
        run(16'hF000, 1'b1, -1);
        run(16'h6000, 1'b0, 6);
        @(negedge clk);
        check("mid_multi_reset", obs, rst_v);
        @(negedge clk);
        check("mid_multi_reset_hold", obs, rst_v);
        reset = 1'b0;
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  op;
            logic [11:0] lo;
            op = 4'($urandom_range(0, 15));
            lo = 12'($urandom);
            run({op, lo}, 1'($urandom_range(0, 1)), -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
